finn_pe_seq: RTL and testbench
==============================

// Module: finn_pe_seq
// PURPOSE
//  Folded binarised (XNOR-popcount) processing element with its own fold/neuron sequencer,
//  valid/ready streaming on input and output, and multi-level thresholding.
//  Successor of the single-threshold PE: one instance per PE lane inside an MVTU; weights and
//  thresholds are serially loaded, then the block runs pix_count output rounds autonomously.
// PARAMETERS
//  SIMD      32   input/weight bits per beat (must be a multiple of 3 when MAJORITY=1)
//  FOLDS     18   beats accumulated per neuron output
//  NEURONS   2    neurons time-multiplexed on this PE
//  TLEVELS   1    thresholds per neuron; out_data = number of levels exceeded
//  MAJORITY  0    1: popcount of 3-bit majority groups (SIMD/3 terms) instead of SIMD XNOR bits
//  ACC_W     clog2(SIMD*FOLDS+1)   accumulator / threshold width
//  OUT_W     clog2(TLEVELS+1)      output width
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high
//  w_load_en  in   1        weight word write strobe (serial load)
//  w_load_data in  SIMD     weight word
//  t_load_en  in   1        threshold write strobe (serial load)
//  t_load_data in  ACC_W    threshold value
//  pix_count  in   16       output rounds per run (one round = NEURONS outputs)
//  start      in   1        begin run (sampled in IDLE only)
//  busy       out  1        1 when not in IDLE
//  done       out  1        one-cycle pulse when run completes
//  in_valid   in   1        input beat valid
//  in_ready   out  1        input beat accepted when in_valid&in_ready
//  in_data    in   SIMD     activation bits
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accept
//  out_data   out  OUT_W    thresholded result
// BEHAVIOUR
//  Reset: state=IDLE; busy,done,out_valid,in_ready=0; out_data=0; all counters and load pointers=0.
//   Weight/threshold arrays are not cleared (contents survive reset).
//  Memories: WMEM depth NEURONS*FOLDS, TMEM depth NEURONS*TLEVELS. Load strobes honoured only in
//   IDLE (ignored otherwise); each strobe writes at pointer then pointer++, wrapping to 0 after
//   depth-1. start also clears both load pointers. Word index n*FOLDS+f; threshold index n*TLEVELS+l.
//  FSM IDLE -> ACC on start && pix_count!=0 (start with pix_count==0 ignored); fold=neuron=round=0.
//  ACC: in_ready=1. On handshake: pop = popcount(~(in_data^W[n*FOLDS+f])) or majority variant;
//   acc <= (f==0) ? pop : acc+pop; f++. On beat f==FOLDS-1: sum=(f==0?pop:acc+pop);
//   out_data <= count of l with sum > T[n*TLEVELS+l] (unsigned); out_valid<=1; f<=0; -> HOLD.
//   Latency: out_valid high the cycle after the last fold beat.
//  HOLD: in_ready=0; out_data/out_valid stable until out_valid&&out_ready. On handshake:
//   out_valid<=0; n++ (wrap at NEURONS, round++ on wrap); if wrap and round==pix_count-1 -> IDLE
//   with done=1 for one cycle, else -> ACC.
//  Accumulator cannot overflow by ACC_W sizing. pix_count sampled at start; later changes ignored.
//  Reset asserted mid-run: immediate return to IDLE next edge, partial sum discarded, no done pulse.
// TESTING
//  Load all-1 weights, thresholds T={100,300}, SIMD=32,FOLDS=18,NEURONS=2; stream 18 all-1 beats
//   -> sum=576, out_data=1 (TLEVELS=1, T0=100); neuron 1 (T=300) -> out_data=1; done after round.
//  in_data = ~weights every beat -> sum=0 -> out_data=0 for both neurons.
//  TLEVELS=3, T={10,20,30}, sum=25 -> out_data=2; sum=30 -> out_data=2 (strict >).
//  Hold out_ready=0 for 5 cycles -> out_valid,out_data stable, in_ready=0, no beats consumed.
//  MAJORITY=1, SIMD=6: in=6'b000111, W=6'b000000 -> groups majority {0,1}... pop=1 per beat.
//  start with pix_count=0 -> stays IDLE, busy=0; reset after 7 beats -> IDLE, next run correct.

Source files
------------

// File: rtl/finn_pe_seq.sv
// Folded XNOR-popcount processing element with its own fold/neuron/round sequencer,
// valid/ready streaming ports and multi-level thresholding against serially loaded memories.
module finn_pe_seq #(
    parameter int SIMD     = 32,
    parameter int FOLDS    = 18,
    parameter int NEURONS  = 2,
    parameter int TLEVELS  = 1,
    parameter int MAJORITY = 0,
    parameter int ACC_W    = $clog2(SIMD * FOLDS + 1),
    parameter int OUT_W    = $clog2(TLEVELS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_load_en,
    input  logic [SIMD-1:0]  w_load_data,
    input  logic             t_load_en,
    input  logic [ACC_W-1:0] t_load_data,
    input  logic [15:0]      pix_count,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIMD-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int WDEPTH = NEURONS * FOLDS;
    localparam int TDEPTH = NEURONS * TLEVELS;
    localparam int WPTR_W = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
    localparam int TPTR_W = (TDEPTH > 1) ? $clog2(TDEPTH) : 1;
    localparam int F_W    = (FOLDS > 1) ? $clog2(FOLDS) : 1;
    localparam int N_W    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int GROUPS = SIMD / 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [SIMD-1:0]  wmem [WDEPTH];
    logic [ACC_W-1:0] tmem [TDEPTH];

    logic [1:0]        state;
    logic [WPTR_W-1:0] w_ptr;
    logic [TPTR_W-1:0] t_ptr;
    logic [F_W-1:0]    fold;
    logic [N_W-1:0]    neuron;
    logic [15:0]       round;
    logic [15:0]       pix_lim;

    logic [WPTR_W-1:0] w_rd_idx;
    logic [ACC_W-1:0]  pop_p0;
    logic [ACC_W-1:0]  sum_p0;
    logic [OUT_W-1:0]  lvl_p0;
    logic [ACC_W-1:0]  acc_p1;
    logic              beat_hs;

    // Agreement count of one beat: plain XNOR bits, or 3-bit majority votes of them.
    function automatic logic [ACC_W-1:0] beat_pop(input logic [SIMD-1:0] act,
                                                  input logic [SIMD-1:0] wgt);
        logic [SIMD-1:0]  agree;
        logic [ACC_W-1:0] cnt;
        agree = ~(act ^ wgt);
        cnt   = '0;
        if (MAJORITY != 0) begin
            for (int g = 0; g < GROUPS; g++) begin
                cnt += ACC_W'((agree[3*g] & agree[3*g+1]) | (agree[3*g] & agree[3*g+2]) |
                              (agree[3*g+1] & agree[3*g+2]));
            end
        end else begin
            for (int i = 0; i < SIMD; i++) begin
                cnt += ACC_W'(agree[i]);
            end
        end
        return cnt;
    endfunction

    function automatic logic thresh_hit(input logic [ACC_W-1:0] sum,
                                        input logic [ACC_W-1:0] thr);
        return sum > thr;
    endfunction

    assign busy     = (state != IDLE);
    assign in_ready = (state == ACC);
    assign beat_hs  = in_ready & in_valid;
    assign w_rd_idx = WPTR_W'(32'(neuron) * FOLDS + 32'(fold));

    // Stage 0: popcount, running sum and threshold levels for the current beat
    assign pop_p0 = beat_pop(in_data, wmem[w_rd_idx]);
    assign sum_p0 = (fold == '0) ? pop_p0 : acc_p1 + pop_p0;

    always_comb begin
        lvl_p0 = '0;
        for (int l = 0; l < TLEVELS; l++) begin
            lvl_p0 += OUT_W'(thresh_hit(sum_p0, tmem[TPTR_W'(32'(neuron) * TLEVELS + l)]));
        end
    end

    // Stage 1: accumulator and parameter memories (no reset, contents survive it)
    always_ff @(posedge clk) begin
        if (beat_hs) acc_p1 <= sum_p0;
        if (state == IDLE && w_load_en) wmem[w_ptr] <= w_load_data;
        if (state == IDLE && t_load_en) tmem[t_ptr] <= t_load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            w_ptr     <= '0;
            t_ptr     <= '0;
            fold      <= '0;
            neuron    <= '0;
            round     <= '0;
            pix_lim   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (w_load_en) w_ptr <= (w_ptr == WPTR_W'(WDEPTH - 1)) ? '0 : w_ptr + 1'b1;
                    if (t_load_en) t_ptr <= (t_ptr == TPTR_W'(TDEPTH - 1)) ? '0 : t_ptr + 1'b1;
                    if (start) begin
                        w_ptr <= '0;
                        t_ptr <= '0;
                        if (pix_count != 16'd0) begin
                            pix_lim <= pix_count;
                            fold    <= '0;
                            neuron  <= '0;
                            round   <= '0;
                            state   <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        if (fold == F_W'(FOLDS - 1)) begin
                            out_data  <= lvl_p0;
                            out_valid <= 1'b1;
                            fold      <= '0;
                            state     <= HOLD;
                        end else begin
                            fold <= fold + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (neuron == N_W'(NEURONS - 1)) begin
                            neuron <= '0;
                            round  <= round + 16'd1;
                            if (round == pix_lim - 16'd1) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= ACC;
                            end
                        end else begin
                            neuron <= neuron + 1'b1;
                            state  <= ACC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_finn_pe_seq.sv
// Bench for finn_pe_seq: a default-sized XNOR instance and a small majority/3-level instance,
// checked against a sum-and-count reference model of folds, neurons and rounds.
module tb_finn_pe_seq;

    localparam int SA = 32, FA = 18, NA = 2, LA = 1;
    localparam int SB = 30, FB = 3, NB = 2, LB = 3;

    logic        clk, rst, sel;
    logic        w_load_en, t_load_en, start, in_valid, out_ready;
    logic [31:0] w_load_data, in_data;
    logic [9:0]  t_load_data;
    logic [15:0] pix_count;

    logic       wen_a, ten_a, st_a, iv_a, wen_b, ten_b, st_b, iv_b;
    logic       busy_a, done_a, in_ready_a, out_valid_a;
    logic       busy_b, done_b, in_ready_b, out_valid_b;
    logic [0:0] out_data_a;
    logic [1:0] out_data_b;

    assign wen_a = w_load_en & ~sel;
    assign ten_a = t_load_en & ~sel;
    assign st_a  = start & ~sel;
    assign iv_a  = in_valid & ~sel;
    assign wen_b = w_load_en & sel;
    assign ten_b = t_load_en & sel;
    assign st_b  = start & sel;
    assign iv_b  = in_valid & sel;

    finn_pe_seq #(.SIMD(SA), .FOLDS(FA), .NEURONS(NA), .TLEVELS(LA), .MAJORITY(0)) dut_a (
        .clk(clk), .reset(rst), .w_load_en(wen_a), .w_load_data(w_load_data),
        .t_load_en(ten_a), .t_load_data(t_load_data), .pix_count(pix_count), .start(st_a),
        .busy(busy_a), .done(done_a), .in_valid(iv_a), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a));

    finn_pe_seq #(.SIMD(SB), .FOLDS(FB), .NEURONS(NB), .TLEVELS(LB), .MAJORITY(1)) dut_b (
        .clk(clk), .reset(rst), .w_load_en(wen_b), .w_load_data(w_load_data[29:0]),
        .t_load_en(ten_b), .t_load_data(t_load_data[6:0]), .pix_count(pix_count), .start(st_b),
        .busy(busy_b), .done(done_b), .in_valid(iv_b), .in_ready(in_ready_b),
        .in_data(in_data[29:0]), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b));

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    // Reference state: what the memories should hold and what outputs are owed.
    logic [31:0] wa [NA*FA];
    int          ta [NA*LA];
    logic [29:0] wb [NB*FB];
    int          tbt[NB*LB];
    int          exp_a[$], exp_b[$];
    logic [31:0] beat_q[$];

    int errors = 0, checks = 0;
    int beats_a = 0, beats_b = 0, dones_a = 0, dones_b = 0;
    int rdy_mode = 2;
    bit abort_run;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int pop_a(input logic [31:0] d, input logic [31:0] w);
        return $countones(~(d ^ w));
    endfunction

    function automatic int pop_b(input logic [29:0] d, input logic [29:0] w);
        logic [29:0] e;
        int c;
        e = ~(d ^ w);
        c = 0;
        for (int g = 0; g < 10; g++) if ($countones(e[3*g +: 3]) >= 2) c++;
        return c;
    endfunction

    function automatic int lv3(input int s, input int t0, input int t1, input int t2);
        return int'(s > t0) + int'(s > t1) + int'(s > t2);
    endfunction

    // Beat whose majority-vote count against all-zero weights is exactly k.
    function automatic logic [29:0] kbeat(input int k);
        logic [29:0] ones;
        ones = '1;
        return (k >= 10) ? 30'd0 : ones << (3 * k);
    endfunction

    // Single compare process: output handshakes, hold stability, ready exclusivity.
    logic       pv_a, pv_b;
    logic [0:0] pd_a;
    logic [1:0] pd_b;
    initial begin
        pv_a = 1'b0;
        pv_b = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv_a = 1'b0;
                pv_b = 1'b0;
            end else begin
                if (pv_a) check("hold_stable_a", int'({out_valid_a, out_data_a}), int'({1'b1, pd_a}));
                if (pv_b) check("hold_stable_b", int'({out_valid_b, out_data_b}), int'({1'b1, pd_b}));
                if (out_valid_a) check("in_ready_during_hold_a", int'(in_ready_a), 0);
                if (out_valid_b) check("in_ready_during_hold_b", int'(in_ready_b), 0);
                if (out_valid_a && out_ready) begin
                    if (exp_a.size() == 0) fail_now("unexpected_out_a");
                    else check("out_a", int'(out_data_a), exp_a.pop_front());
                end
                if (out_valid_b && out_ready) begin
                    if (exp_b.size() == 0) fail_now("unexpected_out_b");
                    else check("out_b", int'(out_data_b), exp_b.pop_front());
                end
                pv_a = out_valid_a && !out_ready;
                pv_b = out_valid_b && !out_ready;
                pd_a = out_data_a;
                pd_b = out_data_b;
                if (iv_a && in_ready_a) beats_a++;
                if (iv_b && in_ready_b) beats_b++;
                if (done_a) dones_a++;
                if (done_b) dones_b++;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 9) < 7);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [31:0] d);
        w_load_data = d;
        w_load_en = 1'b1;
        tick();
        w_load_en = 1'b0;
    endtask

    task automatic load_t(input int d);
        t_load_data = 10'(d);
        t_load_en = 1'b1;
        tick();
        t_load_en = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        int n;
        n = 0;
        in_data = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!(sel ? in_ready_b : in_ready_a) && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (n >= 400) begin
            fail_now("beat_accept_timeout");
            abort_run = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) tick();
    endtask

    task automatic start_run(input bit s, input int p);
        sel = s;
        pix_count = 16'(p);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Fill beat_q for instance A; mode 0 random, 1 all ones, 2 inverse of weights.
    task automatic gen_a(input int p, input int mode, input bit use_model);
        for (int r = 0; r < p; r++)
            for (int n = 0; n < NA; n++) begin
                int s;
                s = 0;
                for (int f = 0; f < FA; f++) begin
                    logic [31:0] d;
                    d = (mode == 0) ? $urandom : (mode == 1) ? 32'hFFFF_FFFF : ~wa[n*FA+f];
                    s += pop_a(d, wa[n*FA+f]);
                    beat_q.push_back(d);
                end
                if (use_model) exp_a.push_back(int'(s > ta[n]));
            end
    endtask

    task automatic gen_b(input int p);
        for (int r = 0; r < p; r++)
            for (int n = 0; n < NB; n++) begin
                int s;
                s = 0;
                for (int f = 0; f < FB; f++) begin
                    logic [29:0] d;
                    d = 30'($urandom);
                    s += pop_b(d, wb[n*FB+f]);
                    beat_q.push_back({2'b00, d});
                end
                exp_b.push_back(lv3(s, tbt[n*LB], tbt[n*LB+1], tbt[n*LB+2]));
            end
    endtask

    task automatic run(input bit s, input int p, input bit junk);
        int b0, d0, n;
        b0 = s ? beats_b : beats_a;
        d0 = s ? dones_b : dones_a;
        abort_run = 1'b0;
        start_run(s, p);
        if (junk) begin
            w_load_data = 32'd0;
            t_load_data = 10'd500;
            w_load_en = 1'b1;
            t_load_en = 1'b1;
            tick();
            w_load_en = 1'b0;
            t_load_en = 1'b0;
        end
        foreach (beat_q[i]) if (!abort_run) send_beat(beat_q[i]);
        beat_q.delete();
        n = 0;
        @(negedge clk);
        while (!(s ? done_b : done_a) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(n < 2000), 1);
        @(negedge clk);
        check("busy_after_done", int'(s ? busy_b : busy_a), 0);
        check("done_pulses", (s ? dones_b : dones_a) - d0, 1);
        check("beats_consumed", (s ? beats_b : beats_a) - b0, p * (s ? NB * FB : NA * FA));
        check("outputs_owed", s ? exp_b.size() : exp_a.size(), 0);
        exp_a.delete();
        exp_b.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [29:0] pat;
        rst = 1'b1; sel = 1'b0; w_load_en = 1'b0; t_load_en = 1'b0; start = 1'b0;
        in_valid = 1'b0; w_load_data = '0; t_load_data = '0; in_data = '0; pix_count = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_state_a", int'({busy_a, done_a, out_valid_a, in_ready_a, out_data_a}), 0);
        check("reset_state_b", int'({busy_b, done_b, out_valid_b, in_ready_b, out_data_b}), 0);

        // Model pins against hand-worked values.
        pat = {5{6'b000111}};
        check("pin_pop_a_ones", pop_a('1, '1), 32);
        check("pin_pop_b_pattern", pop_b(pat, 30'd0), 5);
        check("pin_lv3_25", lv3(25, 10, 20, 30), 2);
        check("pin_lv3_30", lv3(30, 10, 20, 30), 2);

        // All-ones weights and beats: sum 576 beats both thresholds 100 and 300.
        sel = 1'b0;
        for (int i = 0; i < NA*FA; i++) begin wa[i] = '1; load_w('1); end
        ta[0] = 100; ta[1] = 300;
        load_t(100); load_t(300);
        exp_a.push_back(1); exp_a.push_back(1);
        gen_a(1, 1, 0);
        run(0, 1, 1);

        exp_a.push_back(0); exp_a.push_back(0);
        gen_a(1, 2, 0);
        run(0, 1, 0);

        rdy_mode = 0;
        gen_a(2, 0, 1);
        run(0, 2, 0);

        // start with pix_count==0 is ignored.
        sel = 1'b0; pix_count = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("zero_pix_busy", int'(busy_a), 0);
        check("zero_pix_in_ready", int'(in_ready_a), 0);

        // Random weights and thresholds near the expected mean sum.
        for (int i = 0; i < NA*FA; i++) begin wa[i] = $urandom; load_w(wa[i]); end
        for (int i = 0; i < NA*LA; i++) begin ta[i] = $urandom_range(270, 306); load_t(ta[i]); end
        gen_a(3, 0, 1);
        run(0, 3, 0);

        // Downstream stall: result held, no input accepted.
        rdy_mode = 1;
        gen_a(1, 0, 1);
        fork
            run(0, 1, 0);
            begin
                int n, b0;
                n = 0;
                @(negedge clk);
                while (!out_valid_a && n < 1000) begin @(negedge clk); n++; end
                b0 = beats_a;
                repeat (5) @(negedge clk);
                check("stall_out_valid", int'(out_valid_a), 1);
                check("stall_in_ready", int'(in_ready_a), 0);
                check("stall_no_beats", beats_a - b0, 0);
                rdy_mode = 0;
            end
        join

        // Reset after 7 beats: back to IDLE, no result, no done.
        begin
            int d0;
            d0 = dones_a;
            start_run(0, 1);
            for (int i = 0; i < 7; i++) send_beat($urandom);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("midrun_reset_state", int'({busy_a, out_valid_a, in_ready_a, out_data_a}), 0);
            repeat (3) tick();
            check("midrun_reset_no_done", dones_a - d0, 0);
        end
        gen_a(2, 0, 1);
        run(0, 2, 0);

        // Instance B: weight pointer wraps, extra word overwrites word 0.
        sel = 1'b1;
        for (int i = 0; i < NB*FB; i++) begin wb[i] = 30'($urandom); load_w({2'b00, wb[i]}); end
        wb[0] = 30'($urandom);
        load_w({2'b00, wb[0]});
        for (int i = 0; i < NB*LB; i++) begin tbt[i] = $urandom_range(0, 30); load_t(tbt[i]); end
        gen_b(3);
        run(1, 3, 0);

        // Directed three-level thresholds: sums 25 and 30 both give 2 levels.
        sel = 1'b1;
        for (int i = 0; i < NB*FB; i++) begin wb[i] = '0; load_w(32'd0); end
        for (int n = 0; n < NB; n++) begin
            tbt[n*LB] = 10; tbt[n*LB+1] = 20; tbt[n*LB+2] = 30;
            load_t(10); load_t(20); load_t(30);
        end
        beat_q.push_back({2'b00, kbeat(10)}); beat_q.push_back({2'b00, kbeat(10)});
        beat_q.push_back({2'b00, kbeat(5)});
        for (int f = 0; f < FB; f++) beat_q.push_back({2'b00, kbeat(10)});
        exp_b.push_back(2); exp_b.push_back(2);
        run(1, 1, 0);

        // Majority pattern 000111 per 6 bits: 5 per beat, 15 -> 1 level; all-disagree -> 0.
        for (int f = 0; f < FB; f++) beat_q.push_back({2'b00, pat});
        for (int f = 0; f < FB; f++) beat_q.push_back({2'b00, kbeat(0)});
        exp_b.push_back(1); exp_b.push_back(0);
        run(1, 1, 0);

        for (int i = 0; i < NB*FB; i++) begin wb[i] = 30'($urandom); load_w({2'b00, wb[i]}); end
        gen_b(4);
        run(1, 4, 0);

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
